mem_seq: RTL
============

Name: mem_seq

Overview:
- Memory access sequencer placed directly upstream of the unified instruction/data memory in the multicycle processor.
- Owns the PC and arbitrates instruction-fetch and load/store requests from the core.
- Drives the memory's address, write-enable and IR-capture strobes.
- Absorbs the memory's one-cycle registered read latency and returns fetch/data completion pulses to the core.

Parameters:
AW, 9, word-address width (512-word memory)
DW, 32, data width
RESET_PC, 0, PC value after reset
CNT_W, 16, width of the completed-fetch counter

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
FREQ  in  1  fetch request, held until FACK
FACK  out  1  one-cycle pulse: instruction present on memory IR path
DREQ  in  1  data request, held until DACK
DWR  in  1  1=store, 0=load; sampled with DREQ
DADDR  in  AW  data word address
DWDATA  in  DW  store data
DACK  out  1  one-cycle pulse: load data valid / store committed
DRDATA  out  DW  registered load data
PC_LD  in  1  load PC from PC_IN
PC_IN  in  AW  branch/jump target
PC  out  AW  current program counter
MRA  out  AW  memory address
MWE  out  2  memory write enable; 2'b01 when writing, else 2'b00
MWD  out  DW  memory write data
MRD  in  DW  memory read data, registered inside memory, valid one cycle after MRA
IRWE  out  2  IR capture enable; 2'b01 for capture, else 2'b00
FCNT  out  CNT_W  completed fetches, saturating

Behaviour:
- Reset (RSTN low, asynchronous): state=IDLE, PC=RESET_PC, DRDATA=0, FCNT=0, latched addr/data/dir=0.
- Reset outputs: FACK=DACK=0, MWE=IRWE=0, MRA=PC.
- Reset mid-transaction aborts it. MWE falls immediately, so an aborted store never writes.
- States: IDLE, F_RD, F_CAP, D_RD, D_CAP, D_WR.
- IDLE:
  - DREQ high: latch DADDR/DWDATA/DWR, go D_WR if DWR else D_RD.
  - Else FREQ high: go F_RD.
  - DREQ has priority over FREQ when both are high.
  - MRA=PC.
- F_RD: MRA=PC; memory samples at the closing edge; next F_CAP.
- F_CAP:
  - IRWE=2'b01 and FACK=1 (both combinational from state). MRD holds the instruction.
  - PC<=PC+1, wrapping 2^AW-1 -> 0.
  - FCNT+1, saturating at all-ones.
  - Next IDLE.
- D_RD: MRA=latched addr; next D_CAP.
- D_CAP: DRDATA<=MRD at the closing edge; DACK=1; next IDLE.
  - DRDATA is visible from the cycle after DACK and holds until the next load completes.
  - Verification must sample DRDATA one cycle after DACK.
- D_WR: MRA=latched addr, MWD=latched data, MWE=2'b01 for exactly one cycle, DACK=1; next IDLE.
- MWD equals the latched store data in all states; it is don't-care outside D_WR.
- Latency from request seen in IDLE to ACK:
  - Fetch: 2 cycles.
  - Load: 2 cycles.
  - Store: 1 cycle.
- Requests are sampled only in IDLE. A request still high in the cycle after ACK is a new transaction. DADDR/DWDATA changes after acceptance are ignored.
- PC update priority: PC_LD > F_CAP increment > hold.
  - PC_LD during F_RD: the in-flight fetch uses the old PC (already sampled by memory); PC becomes PC_IN.
  - PC_LD during F_CAP: PC_IN wins, no increment.
- MWE and IRWE are never both nonzero. MWE is nonzero only in D_WR; IRWE is nonzero only in F_CAP.

Test Plan:
- Reset then FREQ=1 with mem[0]=0x8C010014: FACK in 2nd cycle after IDLE, IRWE=01 that cycle, IR=0x8C010014, PC 0->1, FCNT=1.
- Load DADDR=20 (mem[20]=17): MRA=20 two cycles, DACK on 2nd, DRDATA=17 next cycle. Repeat for addr 22: DRDATA=0xFFFFFFFB.
- Store DADDR=30, DWDATA=0xDEADBEEF: one cycle MWE=01, MRA=30, DACK=1. Subsequent load of 30 returns 0xDEADBEEF.
- DREQ and FREQ both high in IDLE: data transaction first, fetch starts the cycle after DACK; PC unchanged until that fetch's F_CAP.
- PC=511, fetch: PC wraps to 0. PC_LD=1, PC_IN=100 asserted during F_CAP: PC=100, not 0.
- Store accepted, RSTN pulsed low mid-D_WR before edge: MWE drops immediately, target word unchanged, state IDLE, PC=RESET_PC.

Source files
------------

// File: rtl/mem_seq_if.sv
// Core/memory-facing signal bundle of the memory access sequencer.
// The slave side is the sequencer; the master side is its environment (core plus memory).
interface mem_seq_if #(
    parameter int AW    = 9,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             FREQ;
    logic             FACK;
    logic             DREQ;
    logic             DWR;
    logic [AW-1:0]    DADDR;
    logic [DW-1:0]    DWDATA;
    logic             DACK;
    logic [DW-1:0]    DRDATA;
    logic             PC_LD;
    logic [AW-1:0]    PC_IN;
    logic [AW-1:0]    PC;
    logic [AW-1:0]    MRA;
    logic [1:0]       MWE;
    logic [DW-1:0]    MWD;
    logic [DW-1:0]    MRD;
    logic [1:0]       IRWE;
    logic [CNT_W-1:0] FCNT;

    modport slave (
        input  FREQ, DREQ, DWR, DADDR, DWDATA, PC_LD, PC_IN, MRD,
        output FACK, DACK, DRDATA, PC, MRA, MWE, MWD, IRWE, FCNT
    );

    modport master (
        output FREQ, DREQ, DWR, DADDR, DWDATA, PC_LD, PC_IN, MRD,
        input  FACK, DACK, DRDATA, PC, MRA, MWE, MWD, IRWE, FCNT
    );
endinterface

// File: rtl/mem_seq.sv
// Memory access sequencer: owns the PC, arbitrates fetch vs load/store onto the
// unified memory and hides its one-cycle registered read latency.
module mem_seq #(
    parameter int AW       = 9,
    parameter int DW       = 32,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic      CLK,
    input  logic      RSTN,
    mem_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, F_RD, F_CAP, D_RD, D_CAP, D_WR} state_t;

    state_t           state, nxt;
    logic [AW-1:0]    pc, la;
    logic [DW-1:0]    ld, drdata;
    logic [CNT_W-1:0] fcnt;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            pc     <= AW'(RESET_PC);
            la     <= '0;
            ld     <= '0;
            drdata <= '0;
            fcnt   <= '0;
        end else begin
            state <= nxt;
            // Address/data are frozen at acceptance; later bus changes are ignored.
            if (state == IDLE && bus.DREQ) begin
                la <= bus.DADDR;
                ld <= bus.DWDATA;
            end
            if (bus.PC_LD)
                pc <= bus.PC_IN;
            else if (state == F_CAP)
                pc <= pc + 1'b1;
            if (state == F_CAP && fcnt != '1)
                fcnt <= fcnt + 1'b1;
            if (state == D_CAP)
                drdata <= bus.MRD;
        end
    end

    // Strobes decode from state only, so an async reset drops MWE at once.
    always_comb begin
        nxt      = state;
        bus.FACK = 1'b0;
        bus.DACK = 1'b0;
        bus.MWE  = 2'b00;
        bus.IRWE = 2'b00;
        bus.MRA  = pc;
        case (state)
            IDLE: begin
                if (bus.DREQ)
                    nxt = bus.DWR ? D_WR : D_RD;
                else if (bus.FREQ)
                    nxt = F_RD;
            end
            F_RD:  nxt = F_CAP;
            F_CAP: begin
                bus.IRWE = 2'b01;
                bus.FACK = 1'b1;
                nxt      = IDLE;
            end
            D_RD: begin
                bus.MRA = la;
                nxt     = D_CAP;
            end
            D_CAP: begin
                bus.MRA  = la;
                bus.DACK = 1'b1;
                nxt      = IDLE;
            end
            D_WR: begin
                bus.MRA  = la;
                bus.MWE  = 2'b01;
                bus.DACK = 1'b1;
                nxt      = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.MWD    = ld;
    assign bus.PC     = pc;
    assign bus.FCNT   = fcnt;
    assign bus.DRDATA = drdata;
endmodule
